// File: rtl/wb_dbus_pkg.sv
// Shared definitions for the CPU data-bus interconnect: slave indices, region
// bases, decode field position, FSM encoding and default timeout.
package wb_dbus_pkg;

  localparam int NUM_SLAVES_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  localparam int SLV_ROM    = 0;
  localparam int SLV_RAM    = 1;
  localparam int SLV_PERIPH = 2;
  localparam int SLV_DEBUG  = 3;

  // Value of m_adr[DEC_MSB:DEC_LSB] that selects each slave.
  localparam int DEC_MSB = 31;
  localparam int DEC_LSB = 16;
  localparam logic [15:0] SLV_BASE [NUM_SLAVES_DEF] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

endpackage

// File: rtl/wb_dbus_if.sv
// Wishbone data-bus bundle: CPU-side request/response plus the shared slave
// request and per-slave strobes/responses. Handshake: a master request is
// valid while m_cyc & m_stb; it completes in the cycle m_ack or m_err is high.
// A slave is addressed while its s_cyc/s_stb bit is high and completes the
// access in the cycle it raises s_ack or s_err.
interface wb_dbus_if #(parameter int NUM_SLAVES = 4);
  logic [31:0]              m_adr;
  logic [31:0]              m_dat_o;
  logic [3:0]               m_sel;
  logic                     m_we;
  logic                     m_cyc;
  logic                     m_stb;
  logic [31:0]              m_dat_i;
  logic                     m_ack;
  logic                     m_err;
  logic [31:0]              s_adr;
  logic [31:0]              s_dat_o;
  logic [3:0]               s_sel;
  logic                     s_we;
  logic [NUM_SLAVES-1:0]    s_cyc;
  logic [NUM_SLAVES-1:0]    s_stb;
  logic [32*NUM_SLAVES-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]    s_ack;
  logic [NUM_SLAVES-1:0]    s_err;

  // Interconnect view: receives the CPU request, drives the slave side.
  modport slave (
    input  m_adr, m_dat_o, m_sel, m_we, m_cyc, m_stb,
    output m_dat_i, m_ack, m_err,
    output s_adr, s_dat_o, s_sel, s_we, s_cyc, s_stb,
    input  s_dat_i, s_ack, s_err
  );

  // CPU plus slave-model view.
  modport master (
    output m_adr, m_dat_o, m_sel, m_we, m_cyc, m_stb,
    input  m_dat_i, m_ack, m_err,
    input  s_adr, s_dat_o, s_sel, s_we, s_cyc, s_stb,
    output s_dat_i, s_ack, s_err
  );
endinterface

// File: rtl/wb_timeout_counter.sv
// Stall watchdog: counts enabled cycles since the last clear and reports
// when the count reaches LIMIT.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [15:0] LIMIT_W = 16'(LIMIT);

  logic [15:0] r_count;

  // Clear has priority; otherwise count each enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 16'd1;
  end

  assign o_expired = (r_count == LIMIT_W);
endmodule

// File: rtl/wb_dbus_interconnect.sv
// CPU data-bus interconnect: decodes m_adr[31:16] onto up to four slaves,
// one transaction at a time, with an error response for unmapped addresses.
// Optional stall watchdog selected by the WB_DBUS_TIMEOUT_EN macro.
module wb_dbus_interconnect
  import wb_dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int NUM_SLAVES     = NUM_SLAVES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_dbus_if.slave    bus,
  input  logic        timeout_clr,
  output logic        timeout_flag,
  output logic [31:0] timeout_addr,
  output state_t      o_dbg_state
);
  state_t                r_state;
  state_t                w_state_n;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [NUM_SLAVES-1:0] w_dec;
  logic [NUM_SLAVES-1:0] w_cyc;
  logic [31:0]           w_dat;
  logic                  w_ack;
  logic                  w_err;
  logic                  w_sack;
  logic                  w_serr;
  logic                  w_expired;
  logic                  w_timeout;

  // Request fields go to the slaves unregistered.
  assign bus.s_adr   = bus.m_adr;
  assign bus.s_dat_o = bus.m_dat_o;
  assign bus.s_sel   = bus.m_sel;
  assign bus.s_we    = bus.m_we;
  assign bus.s_cyc   = w_cyc;
  assign bus.s_stb   = w_cyc;
  assign bus.m_dat_i = w_dat;
  assign bus.m_ack   = w_ack;
  assign bus.m_err   = w_err;
  assign o_dbg_state = r_state;

  assign w_sack = |(bus.s_ack & r_sel);
  assign w_serr = |(bus.s_err & r_sel);

  // One-hot address decode; all zero means unmapped.
  always_comb begin
    w_dec = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      if (bus.m_adr[DEC_MSB:DEC_LSB] == SLV_BASE[k]) w_dec[k] = 1'b1;
  end

  // State and latched slave select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_n;
      if (r_state == ST_IDLE && w_state_n == ST_ACTIVE) r_sel <= w_dec;
      else if (w_state_n != ST_ACTIVE)                  r_sel <= '0;
    end
  end

  // Next state and all combinational bus outputs. Abort on m_cyc drop beats
  // the watchdog, which beats a slave response; slave err beats slave ack.
  always_comb begin
    w_state_n = r_state;
    w_cyc     = '0;
    w_dat     = '0;
    w_ack     = 1'b0;
    w_err     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.m_cyc && bus.m_stb) w_state_n = (|w_dec) ? ST_ACTIVE : ST_ERR;
      end
      ST_ACTIVE: begin
        if (!bus.m_cyc) begin
          w_state_n = ST_IDLE;
        end else if (w_expired) begin
          w_err     = 1'b1;
          w_timeout = 1'b1;
          w_state_n = ST_IDLE;
        end else begin
          w_cyc = r_sel;
          for (int k = 0; k < NUM_SLAVES; k++)
            if (r_sel[k]) w_dat = w_dat | bus.s_dat_i[32*k +: 32];
          w_err = w_serr;
          w_ack = w_sack & ~w_serr;
          if (w_sack || w_serr) w_state_n = ST_IDLE;
        end
      end
      ST_ERR: begin
        w_err     = 1'b1;
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

`ifdef WB_DBUS_TIMEOUT_EN
  logic r_flag;
  logic [31:0] r_taddr;

  wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state != ST_ACTIVE),
    .i_enable (r_state == ST_ACTIVE && bus.m_cyc && !w_sack && !w_serr && !w_expired),
    .o_expired(w_expired)
  );

  // Sticky timeout flag and address; a new timeout wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag  <= 1'b0;
      r_taddr <= '0;
    end else if (w_timeout) begin
      r_flag  <= 1'b1;
      r_taddr <= bus.m_adr;
    end else if (timeout_clr) begin
      r_flag  <= 1'b0;
    end
  end

  assign timeout_flag = r_flag;
  assign timeout_addr = r_taddr;
`else
  logic w_unused;
  assign w_unused     = timeout_clr ^ (TIMEOUT_CYCLES == 0);
  assign w_expired    = 1'b0;
  assign timeout_flag = 1'b0;
  assign timeout_addr = '0;
`endif
endmodule
